// File: rtl/vga_pkg.sv
// Package: vga_pkg
// Purpose : Shared timing constants and helpers for the VGA raster engine.
//   vgaMode_t        - one complete raster mode (sync/back/active/front, H and V)
//   MODE_640X480_60  - default mode (800 x 525 total)
//   MODE_800X600_72  - alternate mode (1040 x 666 total)
//   tapIdx_e         - bit positions inside the {req,hs,vs} delay-line word
//   spanTotal()      - total period of one axis
package vga_pkg;

    typedef struct packed {
        logic [15:0] hSync;
        logic [15:0] hBack;
        logic [15:0] hAct;
        logic [15:0] hFront;
        logic [15:0] vSync;
        logic [15:0] vBack;
        logic [15:0] vAct;
        logic [15:0] vFront;
    } vgaMode_t;

    localparam vgaMode_t MODE_640X480_60 = '{
        hSync: 16'd96,  hBack: 16'd48, hAct: 16'd640, hFront: 16'd16,
        vSync: 16'd2,   vBack: 16'd33, vAct: 16'd480, vFront: 16'd10
    };

    localparam vgaMode_t MODE_800X600_72 = '{
        hSync: 16'd120, hBack: 16'd64, hAct: 16'd800, hFront: 16'd56,
        vSync: 16'd6,   vBack: 16'd23, vAct: 16'd600, vFront: 16'd37
    };

    localparam int TAP_W = 3;

    typedef enum int {
        TAP_VS  = 0,
        TAP_HS  = 1,
        TAP_VLD = 2
    } tapIdx_e;

    function automatic int spanTotal(input int syncLen, input int backLen,
                                     input int actLen, input int frontLen);
        return syncLen + backLen + actLen + frontLen;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Module : vga_delay_line
// Purpose: W-bit shift register of depth D; D=0 is a plain wire.
// Ports  :
//   iCLK   in  1  clock
//   iRST   in  1  asynchronous active-high reset, clears every stage
//   iData  in  W  word entering the line
//   oData  out W  iData delayed by D cycles
module vga_delay_line #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic [W-1:0] iData,
    output logic [W-1:0] oData
);

    generate
        if (D == 0) begin : gPass
            assign oData = iData;
        end else begin : gPipe
            logic [W-1:0] pipe [D];

            always_ff @(posedge iCLK or posedge iRST) begin
                if (iRST) begin
                    for (int i = 0; i < D; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= iData;
                    for (int i = 1; i < D; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign oData = pipe[D-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_engine.sv
// Module : vga_timing_engine
// Purpose: Parametrised VGA raster generator. Produces pixel coordinates for
//          the host, accepts its colour DATA_LAT cycles later, and delivers
//          colour, syncs and blank to the DAC on the same clock.
// Ports  :
//   iCLK                in  1       pixel clock
//   iRST                in  1       asynchronous active-high reset
//   iRed/iGreen/iBlue   in  COLOR_W host colour for coordinate issued DATA_LAT cycles earlier
//   oCoord_X/oCoord_Y   out CNT_W   visible-area column/row (held outside visible area)
//   oReq                out 1       coordinate is inside the visible area
//   oFrame_Start        out 1       pulse with the H=0,V=0 coordinate
//   oLine_Start         out 1       pulse with every H=0 coordinate
//   oFrame_Cnt          out 16      completed frames (wrapping)
//   oVGA_R/G/B          out COLOR_W DAC colour, 0 while blanked
//   oVGA_H_SYNC/V_SYNC  out 1       syncs, active level HS_POL/VS_POL
//   oVGA_BLANK          out 1       1 = visible (BLANK_N sense)
//   oVGA_SYNC           out 1       tied 0
//   oVGA_CLOCK          out 1       copy of iCLK
module vga_timing_engine
    import vga_pkg::*;
#(
    parameter int COLOR_W  = 10,
    parameter int CNT_W    = 11,
    parameter int H_SYNC   = int'(MODE_640X480_60.hSync),
    parameter int H_BACK   = int'(MODE_640X480_60.hBack),
    parameter int H_ACT    = int'(MODE_640X480_60.hAct),
    parameter int H_FRONT  = int'(MODE_640X480_60.hFront),
    parameter int V_SYNC   = int'(MODE_640X480_60.vSync),
    parameter int V_BACK   = int'(MODE_640X480_60.vBack),
    parameter int V_ACT    = int'(MODE_640X480_60.vAct),
    parameter int V_FRONT  = int'(MODE_640X480_60.vFront),
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int DATA_LAT = 1
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic [CNT_W-1:0]   oCoord_X,
    output logic [CNT_W-1:0]   oCoord_Y,
    output logic               oReq,
    output logic               oFrame_Start,
    output logic               oLine_Start,
    output logic [15:0]        oFrame_Cnt,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_H_SYNC,
    output logic               oVGA_V_SYNC,
    output logic               oVGA_BLANK,
    output logic               oVGA_SYNC,
    output logic               oVGA_CLOCK
);

    localparam int H_TOT = spanTotal(H_SYNC, H_BACK, H_ACT, H_FRONT);
    localparam int V_TOT = spanTotal(V_SYNC, V_BACK, V_ACT, V_FRONT);

    generate
        if (H_TOT >= (1 << CNT_W)) begin : gHTooWide
            $error("vga_timing_engine: H_TOT does not fit in CNT_W bits");
        end
        if (V_TOT >= (1 << CNT_W)) begin : gVTooWide
            $error("vga_timing_engine: V_TOT does not fit in CNT_W bits");
        end
        if (DATA_LAT < 0 || DATA_LAT > 7) begin : gLatRange
            $error("vga_timing_engine: DATA_LAT must be 0..7");
        end
    endgenerate

    // All boundaries pre-cast so every compare is done at CNT_W.
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_SEND  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SEND  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] X0      = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] Y0      = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] X_END   = CNT_W'(H_SYNC + H_BACK + H_ACT);
    localparam logic [CNT_W-1:0] Y_END   = CNT_W'(V_SYNC + V_BACK + V_ACT);

    logic [CNT_W-1:0] hCont;
    logic [CNT_W-1:0] vCont;
    logic             hWrap;
    logic             visible;

    logic             vld_p0;
    logic             hsRaw_p0;
    logic             vsRaw_p0;
    logic [CNT_W-1:0] coordX_p0;
    logic [CNT_W-1:0] coordY_p0;
    logic             frameStart_p0;
    logic             lineStart_p0;
    logic [15:0]      frameCnt_p0;

    logic [TAP_W-1:0] tapIn;
    logic [TAP_W-1:0] tapOut;
    logic             vld_p1;
    logic             hsRaw_p1;
    logic             vsRaw_p1;

    assign hWrap   = (hCont == H_LAST);
    assign visible = (hCont >= X0) && (hCont < X_END) &&
                     (vCont >= Y0) && (vCont < Y_END);

    // ---- raster counters ----
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            hCont <= '0;
            vCont <= '0;
        end else if (hWrap) begin
            hCont <= '0;
            vCont <= (vCont == V_LAST) ? '0 : vCont + 1'b1;
        end else begin
            hCont <= hCont + 1'b1;
        end
    end

    // ---- stage 0: coordinate, raw syncs and strobes registered from the counters ----
    // The frame counter steps alongside the last pixel of the frame, so it
    // reads as "frames completed" from that cycle onward.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            vld_p0        <= 1'b0;
            hsRaw_p0      <= 1'b0;
            vsRaw_p0      <= 1'b0;
            coordX_p0     <= '0;
            coordY_p0     <= '0;
            frameStart_p0 <= 1'b0;
            lineStart_p0  <= 1'b0;
            frameCnt_p0   <= '0;
        end else begin
            vld_p0        <= visible;
            hsRaw_p0      <= (hCont < H_SEND);
            vsRaw_p0      <= (vCont < V_SEND);
            frameStart_p0 <= (hCont == '0) && (vCont == '0);
            lineStart_p0  <= (hCont == '0);
            if (visible) begin
                coordX_p0 <= hCont - X0;
                coordY_p0 <= vCont - Y0;
            end
            if (hWrap && (vCont == V_LAST)) begin
                frameCnt_p0 <= frameCnt_p0 + 16'd1;
            end
        end
    end

    assign oCoord_X     = coordX_p0;
    assign oCoord_Y     = coordY_p0;
    assign oReq         = vld_p0;
    assign oFrame_Start = frameStart_p0;
    assign oLine_Start  = lineStart_p0;
    assign oFrame_Cnt   = frameCnt_p0;

    // ---- stage 1: control bits wait DATA_LAT cycles for the host colour ----
    always_comb begin
        tapIn          = '0;
        tapIn[TAP_VLD] = vld_p0;
        tapIn[TAP_HS]  = hsRaw_p0;
        tapIn[TAP_VS]  = vsRaw_p0;
    end

    vga_delay_line #(
        .W (TAP_W),
        .D (DATA_LAT)
    ) uDelay (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iData (tapIn),
        .oData (tapOut)
    );

    assign vld_p1   = tapOut[TAP_VLD];
    assign hsRaw_p1 = tapOut[TAP_HS];
    assign vsRaw_p1 = tapOut[TAP_VS];

    // ---- stage 2: DAC output register ----
    // This register is the final of the DATA_LAT+1 alignment cycles: it
    // captures the host colour in the same cycle the matching control bits
    // leave the delay line, so colour, blank and syncs switch together.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oVGA_R      <= '0;
            oVGA_G      <= '0;
            oVGA_B      <= '0;
            oVGA_BLANK  <= 1'b0;
            oVGA_H_SYNC <= ~HS_POL;
            oVGA_V_SYNC <= ~VS_POL;
        end else begin
            oVGA_R      <= vld_p1 ? iRed   : '0;
            oVGA_G      <= vld_p1 ? iGreen : '0;
            oVGA_B      <= vld_p1 ? iBlue  : '0;
            oVGA_BLANK  <= vld_p1;
            oVGA_H_SYNC <= hsRaw_p1 ~^ HS_POL;
            oVGA_V_SYNC <= vsRaw_p1 ~^ VS_POL;
        end
    end

    assign oVGA_SYNC  = 1'b0;
    assign oVGA_CLOCK = iCLK;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Bench for vga_timing_engine: three instances (small mode with DATA_LAT=3,
// tiny high-polarity mode with DATA_LAT=0, default 640x480 with DATA_LAT=1)
// compared every cycle against an arithmetic raster model.
module tb_vga_timing_engine;

    localparam int NI   = 3;
    localparam int NCYC = 5000;

    typedef struct packed {
        int hs, hb, ha, hf, vs, vb, va, vf, dl, hp, vp;
    } mode_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        req;
        logic        fs;
        logic        ls;
        logic [15:0] fc;
        logic [9:0]  r;
        logic [9:0]  g;
        logic [9:0]  b;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        sync;
        logic        vclk;
    } obs_t;

    localparam mode_t MS = '{hs:2, hb:2, ha:8,   hf:2,  vs:2, vb:2,  va:4,   vf:2,  dl:3, hp:0, vp:0};
    localparam mode_t MP = '{hs:3, hb:1, ha:5,   hf:2,  vs:1, vb:2,  va:3,   vf:1,  dl:0, hp:1, vp:1};
    localparam mode_t MD = '{hs:96, hb:48, ha:640, hf:16, vs:2, vb:33, va:480, vf:10, dl:1, hp:0, vp:0};

    logic       clk = 1'b0;
    logic       rstA;
    logic       rstD;
    logic [9:0] red   [NI];
    logic [9:0] green [NI];
    logic [9:0] blue  [NI];
    obs_t       obs   [NI];

    always #5 clk = ~clk;

    logic [10:0] s_x, s_y, p_x, p_y, d_x, d_y;
    logic        s_req, s_fs, s_ls, p_req, p_fs, p_ls, d_req, d_fs, d_ls;
    logic [15:0] s_fc, p_fc, d_fc;
    logic [9:0]  s_r, s_g, s_b, p_r, p_g, p_b, d_r, d_g, d_b;
    logic        s_hs, s_vs, s_bl, s_sy, s_ck;
    logic        p_hs, p_vs, p_bl, p_sy, p_ck;
    logic        d_hs, d_vs, d_bl, d_sy, d_ck;

    vga_timing_engine #(
        .H_SYNC(MS.hs), .H_BACK(MS.hb), .H_ACT(MS.ha), .H_FRONT(MS.hf),
        .V_SYNC(MS.vs), .V_BACK(MS.vb), .V_ACT(MS.va), .V_FRONT(MS.vf),
        .HS_POL(1'b0), .VS_POL(1'b0), .DATA_LAT(MS.dl)
    ) dutS (
        .iCLK(clk), .iRST(rstA), .iRed(red[0]), .iGreen(green[0]), .iBlue(blue[0]),
        .oCoord_X(s_x), .oCoord_Y(s_y), .oReq(s_req), .oFrame_Start(s_fs),
        .oLine_Start(s_ls), .oFrame_Cnt(s_fc), .oVGA_R(s_r), .oVGA_G(s_g), .oVGA_B(s_b),
        .oVGA_H_SYNC(s_hs), .oVGA_V_SYNC(s_vs), .oVGA_BLANK(s_bl), .oVGA_SYNC(s_sy),
        .oVGA_CLOCK(s_ck)
    );

    vga_timing_engine #(
        .H_SYNC(MP.hs), .H_BACK(MP.hb), .H_ACT(MP.ha), .H_FRONT(MP.hf),
        .V_SYNC(MP.vs), .V_BACK(MP.vb), .V_ACT(MP.va), .V_FRONT(MP.vf),
        .HS_POL(1'b1), .VS_POL(1'b1), .DATA_LAT(MP.dl)
    ) dutP (
        .iCLK(clk), .iRST(rstA), .iRed(red[1]), .iGreen(green[1]), .iBlue(blue[1]),
        .oCoord_X(p_x), .oCoord_Y(p_y), .oReq(p_req), .oFrame_Start(p_fs),
        .oLine_Start(p_ls), .oFrame_Cnt(p_fc), .oVGA_R(p_r), .oVGA_G(p_g), .oVGA_B(p_b),
        .oVGA_H_SYNC(p_hs), .oVGA_V_SYNC(p_vs), .oVGA_BLANK(p_bl), .oVGA_SYNC(p_sy),
        .oVGA_CLOCK(p_ck)
    );

    vga_timing_engine #(
        .DATA_LAT(MD.dl)
    ) dutD (
        .iCLK(clk), .iRST(rstD), .iRed(red[2]), .iGreen(green[2]), .iBlue(blue[2]),
        .oCoord_X(d_x), .oCoord_Y(d_y), .oReq(d_req), .oFrame_Start(d_fs),
        .oLine_Start(d_ls), .oFrame_Cnt(d_fc), .oVGA_R(d_r), .oVGA_G(d_g), .oVGA_B(d_b),
        .oVGA_H_SYNC(d_hs), .oVGA_V_SYNC(d_vs), .oVGA_BLANK(d_bl), .oVGA_SYNC(d_sy),
        .oVGA_CLOCK(d_ck)
    );

    assign obs[0] = {s_x, s_y, s_req, s_fs, s_ls, s_fc, s_r, s_g, s_b, s_hs, s_vs, s_bl, s_sy, s_ck};
    assign obs[1] = {p_x, p_y, p_req, p_fs, p_ls, p_fc, p_r, p_g, p_b, p_hs, p_vs, p_bl, p_sy, p_ck};
    assign obs[2] = {d_x, d_y, d_req, d_fs, d_ls, d_fc, d_r, d_g, d_b, d_hs, d_vs, d_bl, d_sy, d_ck};

    int          total = 0;
    int          bad   = 0;
    mode_t       md       [NI];
    int          k        [NI];   // clock edges since reset release
    int          heldX    [NI];
    int          heldY    [NI];
    logic [9:0]  bluePrev [NI];
    logic [10:0] histX    [NI][8];
    logic [10:0] histY    [NI][8];

    task automatic checkEq(input string tag, input logic [79:0] got, input logic [79:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Raster model: edge k shows count k-1 on the coordinate outputs and
    // count k-2-DATA_LAT on the DAC pins; k=0 means held in reset.
    task automatic modelOf(input int i, output obs_t e);
        mode_t m;
        int ht, vt, ft, x0, y0, c, h, v, c2, h2, v2;
        bit vis, vis2;
        m  = md[i];
        ht = m.hs + m.hb + m.ha + m.hf;
        vt = m.vs + m.vb + m.va + m.vf;
        ft = ht * vt;
        x0 = m.hs + m.hb;
        y0 = m.vs + m.vb;
        e      = '0;
        e.vclk = 1'b1;
        e.hs   = ~m.hp[0];
        e.vs   = ~m.vp[0];
        if (k[i] == 0) begin
            heldX[i] = 0;
            heldY[i] = 0;
            return;
        end
        c   = k[i] - 1;
        h   = c % ht;
        v   = (c / ht) % vt;
        vis = (h >= x0) && (h < x0 + m.ha) && (v >= y0) && (v < y0 + m.va);
        if (vis) begin
            heldX[i] = h - x0;
            heldY[i] = v - y0;
        end
        e.x   = 11'(heldX[i]);
        e.y   = 11'(heldY[i]);
        e.req = vis;
        e.fs  = (c % ft) == 0;
        e.ls  = (h == 0);
        e.fc  = 16'((k[i] / ft) % 65536);
        c2 = k[i] - 2 - m.dl;
        if (c2 >= 0) begin
            h2   = c2 % ht;
            v2   = (c2 / ht) % vt;
            vis2 = (h2 >= x0) && (h2 < x0 + m.ha) && (v2 >= y0) && (v2 < y0 + m.va);
            e.blank = vis2;
            e.hs    = (h2 < m.hs) ? m.hp[0] : ~m.hp[0];
            e.vs    = (v2 < m.vs) ? m.vp[0] : ~m.vp[0];
            if (vis2) begin
                e.r = 10'(h2 - x0);
                e.g = 10'(v2 - y0);
                e.b = bluePrev[i];
            end
        end
    endtask

    task automatic checkInst(input int i, input string when);
        obs_t e;
        obs_t o;
        modelOf(i, e);
        o = obs[i];
        checkEq($sformatf("%s.stage0[%0d]", when, i),
                {o.req, o.x, o.y, o.fs, o.ls}, {e.req, e.x, e.y, e.fs, e.ls});
        checkEq($sformatf("%s.frameCnt[%0d]", when, i), o.fc, e.fc);
        checkEq($sformatf("%s.syncBlank[%0d]", when, i),
                {o.blank, o.hs, o.vs, o.sync, o.vclk}, {e.blank, e.hs, e.vs, e.sync, e.vclk});
        checkEq($sformatf("%s.colour[%0d]", when, i), {o.r, o.g, o.b}, {e.r, e.g, e.b});
    endtask

    initial begin
        int  holdCnt;
        int  reqCnt;
        int  lastReqX, lastReqY;
        int  lastFall, lowStart, nFalls;
        logic prevHs;
        int  ftS;
        logic [9:0] nb;

        md[0] = MS;
        md[1] = MP;
        md[2] = MD;
        ftS   = (MS.hs + MS.hb + MS.ha + MS.hf) * (MS.vs + MS.vb + MS.va + MS.vf);
        rstA  = 1'b1;
        rstD  = 1'b1;
        for (int i = 0; i < NI; i++) begin
            k[i] = 0; heldX[i] = 0; heldY[i] = 0; bluePrev[i] = '0;
            red[i] = '0; green[i] = '0; blue[i] = '0;
            for (int j = 0; j < 8; j++) begin
                histX[i][j] = '0;
                histY[i][j] = '0;
            end
        end
        holdCnt = 0; reqCnt = 0; lastReqX = -1; lastReqY = -1;
        lastFall = -1; lowStart = -1; nFalls = 0; prevHs = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) checkInst(i, "reset");
        rstA = 1'b0;
        rstD = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            if (!rstA) begin
                k[0]++;
                k[1]++;
            end
            if (!rstD) k[2]++;
            #1;
            for (int i = 0; i < NI; i++) checkInst(i, "run");

            // Small mode: one frame holds 8x4 requests ending at (7,3).
            if (k[0] == 0) begin
                reqCnt = 0;
            end else if (((k[0] - 1) % ftS) == 0 && (k[0] - 1) >= ftS) begin
                checkEq("reqPerFrame", 80'(reqCnt), 80'd32);
                checkEq("lastCoord", {40'(lastReqX), 40'(lastReqY)}, {40'd7, 40'd3});
                reqCnt = 0;
            end
            if (obs[0].req) begin
                reqCnt++;
                lastReqX = int'(obs[0].x);
                lastReqY = int'(obs[0].y);
            end

            // Default mode: 800-clock line period, 96-clock low sync pulse.
            if (prevHs && !obs[2].hs) begin
                if (lastFall >= 0) checkEq("hPeriod", 80'(cyc - lastFall), 80'd800);
                lastFall = cyc;
                lowStart = cyc;
                nFalls++;
            end else if (!prevHs && obs[2].hs && lowStart >= 0) begin
                checkEq("hsLowWidth", 80'(cyc - lowStart), 80'd96);
            end
            prevHs = obs[2].hs;

            // Host: returns the coordinate seen DATA_LAT cycles ago.
            for (int i = 0; i < NI; i++) begin
                for (int j = 7; j > 0; j--) begin
                    histX[i][j] = histX[i][j-1];
                    histY[i][j] = histY[i][j-1];
                end
                histX[i][0] = obs[i].x;
                histY[i][0] = obs[i].y;
                red[i]      = histX[i][md[i].dl][9:0];
                green[i]    = histY[i][md[i].dl][9:0];
                nb          = ($urandom_range(0, 1) == 1) ? 10'h3FF : 10'($urandom);
                blue[i]     = nb;
                bluePrev[i] = nb;
            end

            // Random 3-clock resets on the small instances after a clean start.
            if (rstA) begin
                holdCnt--;
                if (holdCnt == 0) rstA = 1'b0;
            end else if (cyc > 600 && $urandom_range(0, 199) == 0) begin
                rstA    = 1'b1;
                holdCnt = 3;
                #1;
                k[0] = 0;
                k[1] = 0;
                checkInst(0, "async");
                checkInst(1, "async");
            end
        end

        checkEq("hsFallsSeen", 80'(nFalls >= 2), 80'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
